// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate D-cache controller: 64 sets x 64-byte lines.
// Sequences external tag/data RAMs and a word-level memory port (hit, writeback, refill, replay).
module dcache_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic [3:0]            req_be_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic [ADDR_WIDTH-1:0] tag_addr_o,
    output logic                  tag_wr_en_o,
    output logic                  tag_dirty_o,
    output logic                  tag_valid_o,
    input  logic [21:0]           tag_i,
    output logic [9:0]            data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic [31:0]           data_rdata_i,
    output logic                  mem_valid_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [31:0]           mem_rdata_i
);

    localparam int unsigned KW = $clog2(LINE_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB_READ,
        S_WB_SEND,
        S_REFILL,
        S_UPDATE,
        S_REPLAY
    } state_e;

    state_e         state_q;
    logic [29:0]    addr_q;      // captured byte address [31:2]
    logic           we_q;
    logic [31:0]    wdata_q;
    logic [3:0]     be_q;
    logic [19:0]    vtag_q;
    logic [KW-1:0]  k_q;
    logic [31:0]    wb_data_q;
    logic           wb_hold_q;
    logic           rsp_valid_q;
    logic [31:0]    rsp_rdata_q;

    logic           hit;
    logic           k_last;

    assign hit         = tag_i[20] && (tag_i[19:0] == addr_q[29:10]);
    assign k_last      = (k_q == KW'(LINE_WORDS - 1));
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

    // RAM and memory port drive, decoded from the registered state
    always_comb begin
        req_ready_o  = (state_q == S_IDLE);
        tag_addr_o   = {addr_q, 2'b00};
        tag_wr_en_o  = 1'b0;
        tag_dirty_o  = 1'b0;
        tag_valid_o  = 1'b0;
        data_addr_o  = addr_q[9:0];
        data_we_o    = 1'b0;
        data_be_o    = 4'h0;
        data_wdata_o = 32'h0;
        mem_valid_o  = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = 32'h0;
        case (state_q)
            S_IDLE: begin
                tag_addr_o  = req_addr_i;
                data_addr_o = req_addr_i[11:2];
            end
            S_LOOKUP: begin
                if (hit && we_q) begin
                    data_we_o    = 1'b1;
                    data_be_o    = be_q;
                    data_wdata_o = wdata_q;
                    tag_wr_en_o  = 1'b1;
                    tag_dirty_o  = 1'b1;
                    tag_valid_o  = 1'b1;
                end
            end
            S_WB_READ: begin
                data_addr_o = {addr_q[9:4], k_q};
            end
            S_WB_SEND: begin
                data_addr_o = {addr_q[9:4], k_q};
                mem_valid_o = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {vtag_q, addr_q[9:4], k_q, 2'b00};
                // RAM output is fresh only on the first cycle; later cycles use the held copy
                mem_wdata_o = wb_hold_q ? wb_data_q : data_rdata_i;
            end
            S_REFILL: begin
                data_addr_o = {addr_q[9:4], k_q};
                mem_valid_o = 1'b1;
                mem_addr_o  = {addr_q[29:4], k_q, 2'b00};
                if (mem_ready_i) begin
                    data_we_o    = 1'b1;
                    data_be_o    = 4'hF;
                    data_wdata_o = mem_rdata_i;
                end
            end
            S_UPDATE: begin
                tag_wr_en_o = 1'b1;
                tag_valid_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Control FSM with captured request, counter and response registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            vtag_q      <= '0;
            k_q         <= '0;
            wb_data_q   <= '0;
            wb_hold_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i[31:2];
                        we_q    <= req_we_i;
                        wdata_q <= req_wdata_i;
                        be_q    <= req_be_i;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    k_q <= '0;
                    if (hit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= we_q ? 32'h0 : data_rdata_i;
                        state_q     <= S_IDLE;
                    end else if (tag_i[21] && tag_i[20]) begin
                        vtag_q  <= tag_i[19:0];
                        state_q <= S_WB_READ;
                    end else begin
                        state_q <= S_REFILL;
                    end
                end
                S_WB_READ: begin
                    wb_hold_q <= 1'b0;
                    state_q   <= S_WB_SEND;
                end
                S_WB_SEND: begin
                    if (!wb_hold_q) begin
                        wb_data_q <= data_rdata_i;
                        wb_hold_q <= 1'b1;
                    end
                    if (mem_ready_i) begin
                        wb_hold_q <= 1'b0;
                        if (k_last) begin
                            k_q     <= '0;
                            state_q <= S_REFILL;
                        end else begin
                            k_q     <= k_q + KW'(1);
                            state_q <= S_WB_READ;
                        end
                    end
                end
                S_REFILL: begin
                    if (mem_ready_i) begin
                        if (k_last) begin
                            k_q     <= '0;
                            state_q <= S_UPDATE;
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                    end
                end
                S_UPDATE: state_q <= S_REPLAY;
                S_REPLAY: state_q <= S_LOOKUP;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate D-cache controller.
- Geometry: 64 sets, 64-byte lines (16 x 32-bit words).
- Sits between the CPU load/store port and the word-level memory port.
- Sequences the tag RAM (1-cycle synchronous read, entry {dirty, valid, tag[19:0]}, index addr[11:6], tag addr[31:12]) and the data RAM (1-cycle synchronous read, byte-enable write, word index addr[11:2]).
- Handles hit/miss, dirty-victim writeback, line refill and replay.

Parameters:
- ADDR_WIDTH, 32, byte address width; only 32 supported.
- LINE_WORDS, 16, words per line; fixed by the 6-bit offset.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  CPU request valid.
- req_ready_o  out  1  controller can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address; [1:0] ignored.
- req_wdata_i  in  32  store data.
- req_be_i  in  4  store byte enables.
- rsp_valid_o  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata_o  out  32  load data; valid when rsp_valid_o is high.
- tag_addr_o  out  32  address presented to the tag RAM.
- tag_wr_en_o  out  1  tag RAM write enable.
- tag_dirty_o  out  1  dirty bit to write.
- tag_valid_o  out  1  valid bit to write.
- tag_i  in  22  tag RAM read data: [21] dirty, [20] valid, [19:0] tag.
- data_addr_o  out  10  data RAM word index.
- data_we_o  out  1  data RAM write enable.
- data_be_o  out  4  data RAM byte enables.
- data_wdata_o  out  32  data RAM write data.
- data_rdata_i  in  32  data RAM read data (1-cycle latency).
- mem_valid_o  out  1  memory word request valid.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  32  word-aligned memory address.
- mem_wdata_o  out  32  memory write data.
- mem_ready_i  in  1  memory accepts the word; on a read, mem_rdata_i is valid the same cycle.
- mem_rdata_i  in  32  memory read data.

Behaviour:
- Reset (rst_i low, async): state IDLE, word counter k = 0. All outputs 0 except req_ready_o = 1. Reset mid-burst abandons the transfer: mem_valid_o drops immediately and tag/data RAM contents are untouched.
- Handshake: a request is accepted when req_valid_i & req_ready_o. req_ready_o is 1 only in IDLE. At acceptance, addr/we/wdata/be are captured into internal registers.
- Combinational read issue: in IDLE, tag_addr_o = req_addr_i and data_addr_o = req_addr_i[11:2]. In every other state both come from the captured address or the counter.
- IDLE: on accept -> LOOKUP.
- LOOKUP (tag_i and data_rdata_i valid): hit = tag_i[20] & (tag_i[19:0] == addr[31:12]).
  - Read hit: rsp_rdata_o <= data_rdata_i, rsp_valid_o pulses next cycle -> IDLE.
  - Write hit, same cycle: data_we_o = 1, data_be_o = be, data_wdata_o = wdata; tag_wr_en_o = 1 with dirty = 1, valid = 1. rsp_valid_o pulses next cycle with rsp_rdata_o = 0 -> IDLE.
  - Miss with tag_i[21] & tag_i[20]: latch victim tag, k = 0 -> WB_READ.
  - Other miss: k = 0 -> REFILL.
- Hit latency: accept cycle T, rsp_valid_o at T+2; back-to-back hits give one response per 2 cycles.
- WB_READ: data_addr_o = {index, k} -> WB_SEND.
- WB_SEND: mem_valid_o = 1, mem_we_o = 1, mem_addr_o = {victim_tag, index, k, 2'b00}, mem_wdata_o = data_rdata_i latched on entry and held stable until mem_ready_i. On ready: if k == 15, k = 0 -> REFILL; else k++ -> WB_READ.
- REFILL: mem_valid_o = 1, mem_we_o = 0, mem_addr_o = {addr[31:6], k, 2'b00}. On mem_ready_i, same cycle: data_we_o = 1, data_be_o = 4'hF, data_addr_o = {index, k}, data_wdata_o = mem_rdata_i. If k == 15 -> UPDATE; else k++.
- UPDATE: tag_wr_en_o = 1, dirty = 0, valid = 1, tag_addr_o = captured addr -> REPLAY.
- REPLAY: drive tag and data read addresses from the captured address -> LOOKUP. The replay is guaranteed to hit, and a replayed store sets dirty.
- Counter k is 4-bit. It wraps only via explicit clear at k == 15; there are never more than 16 memory handshakes per phase.
- mem_valid_o, once asserted, stays high with stable address and data until mem_ready_i. Memory wait states of any length are tolerated.
- req_valid_i changes outside IDLE are ignored.

Test Plan:
- After reset, read 0x0000_1040 -> miss, 16 memory reads at 0x1040..0x107C, tag[1] = {0,1,0x00001}, rsp_valid_o with word 0 of the refill data.
- Read hit on 0x0000_1044 -> rsp_valid_o exactly 2 cycles after accept, no mem_valid_o activity.
- Store 0xDEADBEEF, be = 4'b0011 to 0x0000_1048 (hit) -> data RAM word 0x012 bytes [1:0] updated, tag[1] dirty = 1, rsp at T+2.
- Read 0x0000_2040 (same index, dirty) -> 16 memory writes at 0x1040..0x107C including merged 0x....BEEF at 0x1048, then 16 reads at 0x2040.., tag[1] = {0,1,0x00002}.
- mem_ready_i held low 5 cycles per word during writeback -> mem_addr_o and mem_wdata_o stable, no word skipped or duplicated.
- rst_i low at refill word 7 -> mem_valid_o 0 immediately, state IDLE, req_ready_o 1. Next request to the same line misses again (tag unchanged).
